// File: rtl/booth_csa_seq_mult.sv
// Sequential signed multiplier: radix-4 Booth digits folded into a carry-save
// accumulator, one digit per cycle, with a single carry-propagate add at the end.
module booth_csa_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int ND = WIDTH / 2;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [CW-1:0] I_LAST = CW'(ND - 1);
    localparam logic [CW-1:0] I_ONE  = CW'(1);
    localparam logic [PW-1:0] PP_ONE = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ITER    = 2'd1,
        ST_RESOLVE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [PW-1:0]     sum_r;
    logic [PW-1:0]     carry_r;
    logic [PW-1:0]     product_r;
    logic              done_r;
    logic [CW-1:0]     i_r;
    logic [WIDTH:0]    b_ext_s;
    logic [2:0]        trip_tab_s [ND];
    logic [2:0]        trip_s;
    logic [CW:0]       shamt_s;
    logic [PW-1:0]     pp_s;

    // Bitwise majority: the carry output of a row of full adders.
    function automatic logic [PW-1:0] csa_maj(
        input logic [PW-1:0] x,
        input logic [PW-1:0] y,
        input logic [PW-1:0] z
    );
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Unshifted partial product for one Booth triplet, exact two's complement.
    function automatic logic [PW-1:0] booth_pp(
        input logic [WIDTH-1:0] mcand,
        input logic [2:0]       trip
    );
        logic [PW-1:0] ax;
        logic [PW-1:0] mag;
        logic          neg;
        ax  = {{WIDTH{mcand[WIDTH-1]}}, mcand};
        mag = '0;
        neg = 1'b0;
        case (trip)
            3'b001, 3'b010: mag = ax;
            3'b011:         mag = ax << 1'b1;
            3'b100: begin
                mag = ax << 1'b1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = ax;
                neg = 1'b1;
            end
            default:        mag = '0;
        endcase
        if (neg) begin
            return (~mag) + PP_ONE;
        end else begin
            return mag;
        end
    endfunction

    // Multiplier with the implicit b[-1]=0 appended below bit 0.
    assign b_ext_s = {b_r, 1'b0};

    for (genvar k = 0; k < ND; k++) begin : g_trip
        assign trip_tab_s[k] = b_ext_s[2*k +: 3];
    end

    // Select the current Booth triplet and form the aligned partial product.
    always_comb begin
        trip_s  = trip_tab_s[i_r];
        shamt_s = {i_r, 1'b0};
        pp_s    = booth_pp(a_r, trip_s) << shamt_s;
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ITER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (i_r == I_LAST) begin
                    state_nxt_s = ST_RESOLVE;
                end else begin
                    state_nxt_s = ST_ITER;
                end
            end
            ST_RESOLVE: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, carry-save accumulation, final resolve and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            sum_r     <= '0;
            carry_r   <= '0;
            i_r       <= '0;
            product_r <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state_r == ST_RESOLVE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        sum_r   <= '0;
                        carry_r <= '0;
                        i_r     <= '0;
                    end
                end
                ST_ITER: begin
                    // Carry out of the top bit is discarded: everything is mod 2^PW.
                    sum_r   <= sum_r ^ carry_r ^ pp_s;
                    carry_r <= csa_maj(sum_r, carry_r, pp_s) << 1'b1;
                    i_r     <= i_r + I_ONE;
                end
                ST_RESOLVE: begin
                    product_r <= sum_r + carry_r;
                end
                default: begin
                    product_r <= product_r;
                end
            endcase
        end
    end

    assign ready   = (state_r == ST_IDLE);
    assign busy    = (state_r == ST_ITER) || (state_r == ST_RESOLVE);
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_booth_csa_seq_mult.sv
// Directed self-checking bench for booth_csa_seq_mult at WIDTH=16.
module tb_booth_csa_seq_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    booth_csa_seq_mult #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: latency, busy span, hold during ITER, result.
    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] exp);
        int          cyc;
        int          nbusy;
        logic [31:0] prev;
        prev  = product;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        nbusy = 0;
        while (!done && cyc < 30) begin
            if (busy) nbusy++;
            if (cyc == 4) check({tag, "_hold"}, 64'(product), 64'(prev));
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'd9);
        check({tag, "_busy"}, 64'(nbusy), 64'd9);
        check({tag, "_prod"}, 64'(product), 64'(exp));
        check({tag, "_rdy"}, 64'(ready), 64'd1);
        tick();
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [15:0] cx [6];
        logic [15:0] cy [6];
        logic [31:0] cp [6];
        logic [15:0] bx [4];
        logic [15:0] by [4];
        logic [31:0] bp [4];
        int          cyc;
        int          dcount;
        logic [31:0] got;
        int          sa;
        int          sb;

        cx = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000};
        cy = '{16'h8000, 16'h0001, 16'h8000, 16'h0000, 16'hFFFF, 16'hFFFF};
        cp = '{32'h40000000, 32'hFFFFFFFF, 32'hC0008000, 32'h00000000, 32'h00000001, 32'h00008000};
        bx = '{16'd12, 16'h7FFF, 16'hFFFF, 16'd200};
        by = '{16'hFFF4, 16'h7FFF, 16'hFFFF, 16'd300};
        bp = '{32'hFFFFFF70, 32'h3FFF0001, 32'h00000001, 32'h0000EA60};

        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_prod", 64'(product), 64'd0);

        run_op("basic_3x5", 16'd3, 16'd5, 32'h0000000F);

        for (int k = 0; k < 6; k++) begin
            run_op($sformatf("corner%0d", k), cx[k], cy[k], cp[k]);
        end

        // Start held high: each done cycle doubles as the next accept cycle.
        a     = bx[0];
        b     = by[0];
        start = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (!done && cyc < 30) begin
                tick();
                cyc++;
            end
            check($sformatf("b2b%0d_lat", k), 64'(cyc), 64'd9);
            check($sformatf("b2b%0d_prod", k), 64'(product), 64'(bp[k]));
            if (k < 3) begin
                a = bx[k+1];
                b = by[k+1];
            end else begin
                start = 1'b0;
            end
            tick();
        end
        dcount = 0;
        for (int j = 0; j < 12; j++) begin
            if (done) dcount++;
            tick();
        end
        check("b2b_tail_done", 64'(dcount), 64'd0);

        // Operand and start noise while busy must not disturb the captured pair.
        a     = 16'd100;
        b     = 16'hFFFD;
        start = 1'b1;
        tick();
        dcount = 0;
        got    = 32'h0;
        for (int j = 0; j < 14; j++) begin
            if (j < 7) begin
                a     = 16'($urandom);
                b     = 16'($urandom);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                dcount++;
                got = product;
            end
        end
        check("noise_done_cnt", 64'(dcount), 64'd1);
        check("noise_prod", 64'(got), 64'hFFFFFED4);

        // Abort with reset while digit 4 is about to be processed.
        a     = 16'd1234;
        b     = 16'd567;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        check("abort_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_prod", 64'(product), 64'd0);
        dcount = 0;
        for (int j = 0; j < 12; j++) begin
            if (done) dcount++;
            tick();
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        run_op("after_abort", 16'hFFF9, 16'd6, 32'hFFFFFFD6);

        // Reset wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("rst_start_busy", 64'(busy), 64'd0);
        check("rst_start_ready", 64'(ready), 64'd1);

        for (int n = 0; n < 1000; n++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            sa = int'($signed(a));
            sb = int'($signed(b));
            run_op($sformatf("rand%0d", n), a, b, 32'(sa * sb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
